// File: rtl/mips32_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_mem_pkg : shared constants and encodings for the memory responder  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package mips32_mem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 1024;
  localparam int unsigned DEFAULT_AW    = 10;

  typedef logic [0:0] state_t;
  localparam state_t ST_BOOT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_DM   = 2'd2
  } sel_e;

endpackage
`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_mem_arbiter : data-priority arbiter with fetch starvation guard    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_if_req,
  input  logic i_dm_req,
  output sel_e o_sel,
  output logic o_if_gnt,
  output logic o_dm_gnt
);

  localparam int unsigned     CW        = $clog2(STARVE_MAX + 2);
  localparam logic [CW-1:0]   C_CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  sel_e          w_sel;

  // A fetch that has lost STARVE_MAX times in a row overrides data priority once.
  always_comb begin
    w_sel = SEL_NONE;
    if (i_run) begin
      if (i_if_req && (r_cnt == C_CNT_MAX)) begin
        w_sel = SEL_IF;
      end else if (i_dm_req) begin
        w_sel = SEL_DM;
      end else if (i_if_req) begin
        w_sel = SEL_IF;
      end
    end
  end

  assign o_sel    = w_sel;
  assign o_if_gnt = (w_sel == SEL_IF);
  assign o_dm_gnt = (w_sel == SEL_DM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || (w_sel == SEL_IF)) begin
      r_cnt <= '0;
    end else if (i_if_req && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips32_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_mem_responder : boot-loaded single-port memory for IF/MEM stages   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned AW         = DEFAULT_AW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        core_run,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        addr_err
);

  localparam logic [31:0] C_DEPTH = 32'(DEPTH);

  state_t      r_state;
  logic [31:0] r_mem [DEPTH];
  logic        r_if_rvalid;
  logic        r_dm_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_addr_err;

  logic        w_boot;
  logic        w_run;
  logic        w_ld_acc;
  logic        w_ld_inr;
  logic        w_if_inr;
  logic        w_dm_inr;
  sel_e        w_sel;
  logic        w_if_gnt;
  logic        w_dm_gnt;
  logic [31:0] w_rd_addr;
  logic        w_rd_inr;
  logic [31:0] w_rd_word;
  logic        w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [31:0] w_wr_data;

  // Holding rst masks everything visible, including a response already in flight.
  assign w_boot   = (r_state == ST_BOOT) && !rst;
  assign w_run    = (r_state == ST_RUN)  && !rst;
  assign w_ld_acc = w_boot && ld_valid;

  assign w_ld_inr = (ld_addr < C_DEPTH);
  assign w_if_inr = (if_addr < C_DEPTH);
  assign w_dm_inr = (dm_addr < C_DEPTH);

  mips32_mem_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_if_req (if_req),
    .i_dm_req (dm_req),
    .o_sel    (w_sel),
    .o_if_gnt (w_if_gnt),
    .o_dm_gnt (w_dm_gnt)
  );

  assign w_rd_addr = (w_sel == SEL_IF) ? if_addr : dm_addr;
  assign w_rd_inr  = (w_sel == SEL_IF) ? w_if_inr : w_dm_inr;
  assign w_rd_word = w_rd_inr ? r_mem[w_rd_addr[AW-1:0]] : 32'h0;

  // Loader and store never coexist: loader only in BOOT, grants only in RUN.
  assign w_wr_en   = (w_ld_acc && w_ld_inr) || (w_dm_gnt && dm_we && w_dm_inr);
  assign w_wr_idx  = w_ld_acc ? ld_addr[AW-1:0] : dm_addr[AW-1:0];
  assign w_wr_data = w_ld_acc ? ld_data : dm_wdata;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_BOOT;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_dm_rdata  <= 32'h0;
      r_addr_err  <= 1'b0;
    end else begin
      if (w_ld_acc && ld_last) begin
        r_state <= ST_RUN;
      end
      r_if_rvalid <= w_if_gnt;
      r_dm_rvalid <= w_dm_gnt && !dm_we;
      if (w_if_gnt) begin
        r_if_rdata <= w_rd_word;
      end
      if (w_dm_gnt && !dm_we) begin
        r_dm_rdata <= w_rd_word;
      end
      if ((w_ld_acc && !w_ld_inr) || (w_if_gnt && !w_if_inr) || (w_dm_gnt && !w_dm_inr)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign ld_ready  = w_boot;
  assign core_run  = w_run;
  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign if_rvalid = r_if_rvalid && !rst;
  assign dm_rvalid = r_dm_rvalid && !rst;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips32_mem_responder : scoreboard bench with behavioural memory model  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mips32_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        ld_ready, core_run, if_gnt, if_rvalid, dm_gnt, dm_rvalid, addr_err;
  logic [31:0] if_rdata, dm_rdata;

  mips32_mem_responder dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .core_run(core_run),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  int          m_cnt;
  bit          m_err;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic        obs_dm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_last = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  // One clock of the reference model: data beats fetch unless fetch has lost STARVE times running.
  task automatic step();
    logic        eg_if, eg_dm;
    logic [31:0] a;
    @(negedge clk);
    eg_if = 1'b0;
    eg_dm = 1'b0;
    if (m_run) begin
      if (if_req && m_cnt == STARVE) eg_if = 1'b1;
      else if (dm_req)               eg_dm = 1'b1;
      else if (if_req)               eg_if = 1'b1;
    end
    chk1("if_gnt", if_gnt, eg_if);
    chk1("dm_gnt", dm_gnt, eg_dm);
    chk1("ld_ready", ld_ready, !m_run);
    chk1("core_run", core_run, m_run);
    chk1("addr_err", addr_err, m_err);
    obs_dm = dm_gnt;
    if (m_run) begin
      if (eg_if)                         m_cnt = 0;
      else if (if_req && m_cnt < STARVE) m_cnt++;
    end else if (ld_valid) begin
      if (ld_addr < DEPTH) m_mem[ld_addr[9:0]] = ld_data;
      else                 m_err = 1'b1;
      if (ld_last) m_run = 1'b1;
    end
    if (eg_if) begin
      a = if_addr;
      if_q.push_back('{cyc + 1, (a < DEPTH) ? m_mem[a[9:0]] : 32'h0});
      if (a >= DEPTH) m_err = 1'b1;
    end
    if (eg_dm) begin
      a = dm_addr;
      if (a >= DEPTH)  m_err = 1'b1;
      if (dm_we) begin
        if (a < DEPTH) m_mem[a[9:0]] = dm_wdata;
      end else begin
        dm_q.push_back('{cyc + 1, (a < DEPTH) ? m_mem[a[9:0]] : 32'h0});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor, independent of the stimulus thread.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (mon_en) begin
        if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
          e = if_q.pop_front();
          chk1("if_rvalid", if_rvalid, 1'b1);
          chk("if_rdata", if_rdata, e.data);
        end else if (if_rvalid) begin
          chk1("if_rvalid_unexpected", if_rvalid, 1'b0);
        end
        if (dm_q.size() > 0 && dm_q[0].cyc == cyc) begin
          e = dm_q.pop_front();
          chk1("dm_rvalid", dm_rvalid, 1'b1);
          chk("dm_rdata", dm_rdata, e.data);
        end else if (dm_rvalid) begin
          chk1("dm_rvalid_unexpected", dm_rvalid, 1'b0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  pat;
    logic [31:0] d, keep;
    int          a;

    idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_core_run", core_run, 1'b0);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_dm_gnt", dm_gnt, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
    chk1("rst_addr_err", addr_err, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    mon_en = 1'b1;

    // Core requests while still booting must be ignored.
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'd0; dm_addr = 32'd0;
    repeat (3) step();
    idle();

    // Full image load; program words 0..2 go last so ld_last lands on word 2.
    for (int k = 0; k < DEPTH; k++) begin
      a = (k < DEPTH - 3) ? k + 3 : k - (DEPTH - 3);
      case (a)
        0:       d = 32'h2801000A;
        1:       d = 32'h28020014;
        2:       d = 32'hFC000000;
        5:       d = 32'h00000055;
        default: d = $urandom;
      endcase
      ld_valid = 1'b1; ld_addr = 32'(a); ld_data = d; ld_last = (k == DEPTH - 1);
      step();
    end
    idle();
    step();

    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(i);
      step();
    end
    idle();
    step();

    // Contention: expect dm x4, fetch once, dm again.
    if_req = 1'b1; if_addr = 32'd3; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd5;
    for (int i = 0; i < 6; i++) begin
      step();
      pat[i] = obs_dm;
    end
    idle();
    step();
    chk("contention_dm_pattern", {26'h0, pat}, 32'h0000002F);
    chk("contention_dm_rdata", dm_rdata, 32'h00000055);

    // Store then immediate load of the same word.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd7; dm_wdata = 32'hDEADBEEF;
    step();
    dm_we = 1'b0;
    step();
    idle();
    step();
    chk("raw_dm_rdata", dm_rdata, 32'hDEADBEEF);

    // Out-of-range accesses.
    keep = m_mem[976];
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd1024;
    step();
    dm_we = 1'b1; dm_addr = 32'd2000; dm_wdata = 32'h12345678;
    step();
    idle();
    step();
    chk1("range_addr_err", addr_err, 1'b1);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd976;
    step();
    idle();
    step();
    chk("range_alias_untouched", dm_rdata, keep);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if_req   = 1'($urandom_range(0, 1));
      dm_req   = 1'($urandom_range(0, 1));
      dm_we    = 1'($urandom_range(0, 1));
      if_addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      dm_addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      dm_wdata = $urandom;
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'($urandom_range(0, DEPTH - 1));
      ld_data  = $urandom;
      step();
    end
    idle();
    step();

    // Reset in the cycle after a load grant: the response must never appear.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd2;
    step();
    idle();
    rst = 1'b1;
    while (dm_q.size() > 0 && dm_q[$].cyc == cyc) void'(dm_q.pop_back());
    while (if_q.size() > 0 && if_q[$].cyc == cyc) void'(if_q.pop_back());
    @(negedge clk);
    chk1("midrst_dm_rvalid", dm_rvalid, 1'b0);
    chk1("midrst_dm_gnt", dm_gnt, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    step();
    chk("midrst_dm_rdata_cleared", dm_rdata, 32'h0);

    ld_valid = 1'b1; ld_last = 1'b1; ld_addr = 32'd1000; ld_data = $urandom;
    step();
    idle();
    if_req = 1'b1; if_addr = 32'd2;
    step();
    idle();
    step();
    chk("reboot_if_rdata", if_rdata, 32'hFC000000);

    repeat (3) step();
    chk("if_queue_drained", 32'(if_q.size()), 32'h0);
    chk("dm_queue_drained", 32'(dm_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips32_mem_responder.md
Name: mips32_mem_responder

Overview:
- Memory-side responder for the MIPS32 pipeline: services instruction-fetch reads (IF stage) and load/store accesses (MEM stage) from one single-port word-addressed array.
- Also provides the writer end that fills the array: a boot loader stream writes the program/data image before the core is released.
- Sits between the core's fetch/data request ports and the storage. Replaces direct `Mem[]` indexing with a handshaked, arbitrated interface.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- AW, 10, index width; must equal clog2(DEPTH).
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win one cycle.

Ports:
- clk  in  1  single clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader word present.
- ld_ready  out  1  loader word accepted this cycle.
- ld_addr  in  32  loader word address.
- ld_data  in  32  loader word data.
- ld_last  in  1  with ld_valid: final loader word; ends BOOT.
- core_run  out  1  high in RUN; core may issue requests.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch word address (PC).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid (one cycle after if_gnt).
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data word address (EX_MEM_ALUOut).
- dm_wdata  in  32  store data (EX_MEM_B).
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid (one cycle after a load grant).
- dm_rdata  out  32  load data.
- addr_err  out  1  sticky; set by any out-of-range access.

Behaviour:
- Reset: state=BOOT; ld_ready, core_run, if_gnt, if_rvalid, dm_gnt, dm_rvalid, addr_err = 0; if_rdata, dm_rdata = 0; starvation counter = 0. Array contents are not cleared.
- FSM states are BOOT and RUN.
  - BOOT: ld_ready=1 (combinational). The accepted word writes array[ld_addr[AW-1:0]]. ld_valid&ld_last moves to RUN next cycle. if_req/dm_req are ignored (no grants).
  - RUN: ld_ready=0 and core_run=1. RUN→BOOT only via rst.
- Grants are combinational from requests and state; at most one grant per cycle (single port).
- Arbitration in RUN:
  - dm wins over if, matching MEM-stage priority.
  - Each cycle with if_req=1 and no if_gnt increments the starvation counter, saturating at STARVE_MAX.
  - When the counter == STARVE_MAX and if_req=1, fetch wins that cycle and the counter clears.
  - Any if_gnt clears the counter.
- Read latency is exactly 1 cycle. The granted read registers data and asserts its rvalid for one cycle. rdata holds its value until the next rvalid on that channel.
- Writes commit at the grant edge. A read granted the following cycle at the same address returns the new data. There is no same-cycle read/write.
- Range check uses the full 32-bit address: addr >= DEPTH is out of range.
  - Read: rvalid still asserted, rdata = 0.
  - Write or loader word: dropped.
  - All cases set addr_err; it clears only on rst.
- Reset mid-operation: a pending rvalid is suppressed, the FSM returns to BOOT, and the counter clears. Array contents are retained, so a re-boot may reload partially.
- A loader word arriving in RUN is ignored (ld_ready=0).

Decomposition:
- Package mips32_mem_pkg holds:
  - state enum {BOOT, RUN};
  - default DEPTH/AW constants;
  - channel-select encoding {SEL_NONE, SEL_IF, SEL_DM}.
- Sub-module mips32_mem_arbiter: fixed dm priority plus the starvation counter; outputs the select and the grants. The array, range check and response registers stay in the top.

Test Plan:
- Boot load: write 0x2801000A@0, 0x28020014@1, 0xFC000000@2 with ld_last on word 2. Required: core_run rises the next cycle; fetches of 0,1,2 return those words, each rvalid one cycle after its grant.
- Contention: if_req and dm_req (load @5, preloaded 0x55) held high for 6 cycles. Required: dm_gnt on cycles 1-4; if_gnt on cycle 5 (counter hit 4); dm again on cycle 6; dm_rdata=0x55.
- RAW: store 0xDEADBEEF@7, then load @7 on the next cycle. Required: dm_rdata=0xDEADBEEF one cycle after the load grant.
- Range: load @1024, then store @2000. Required: rvalid with dm_rdata=0; array unchanged; addr_err=1 and stays 1 until rst.
- Requests during BOOT: if_req=1, dm_req=1 while ld_valid=0. Required: no grants, no rvalid; core_run=0.
- Mid-run reset: assert rst in the cycle after a load grant. Required: dm_rvalid stays 0; core_run=0 and ld_ready=1 next cycle; addr_err=0; a fetch after re-boot (ld_last only) returns the pre-reset contents.
